// File: rtl/match_pkg.sv
// Shared types and constants for the match sequencer.
// The geometry values must stay in step with the ball physics block.
package match_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned FLOOR_Y  = 400;
    localparam int unsigned GOAL_W   = 80;
    localparam int unsigned GOAL_H   = 150;

    localparam int unsigned DEF_GOAL_CONFIRM   = 2;
    localparam int unsigned DEF_KICKOFF_FRAMES = 90;
    localparam int unsigned DEF_GOAL_FRAMES    = 120;
    localparam int unsigned DEF_FRAMES_PER_SEC = 60;
    localparam int unsigned DEF_MATCH_SECS     = 90;
    localparam int unsigned DEF_WIN_SCORE      = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_KICKOFF = 3'd1,
        ST_PLAY    = 3'd2,
        ST_GOAL    = 3'd3,
        ST_OVER    = 3'd4
    } state_e;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/match_control_if.sv
// Signal bundle between the match sequencer and the ball physics, players and HUD.
interface match_control_if;

    logic       start;
    logic [9:0] BallX;
    logic [9:0] BallY;
    logic [9:0] BallS;
    logic       ball_reset;
    logic       players_frozen;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [6:0] time_left;
    logic       goal_flash;
    logic       scorer;
    logic       game_over;
    logic [2:0] state;

    modport master (
        output start, BallX, BallY, BallS,
        input  ball_reset, players_frozen, score1, score2, time_left,
        input  goal_flash, scorer, game_over, state
    );

    modport slave (
        input  start, BallX, BallY, BallS,
        output ball_reset, players_frozen, score1, score2, time_left,
        output goal_flash, scorer, game_over, state
    );

endinterface

// File: rtl/match_control_goal_detect.sv
// Goal-mouth qualification and N-frame confirmation; emits a one-cycle
// award pulse for the side that scored.
module goal_detect
    import match_pkg::*;
#(
    parameter int unsigned GOAL_CONFIRM = DEF_GOAL_CONFIRM
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic       enable_i,
    input  logic [9:0] ball_x_i,
    input  logic [9:0] ball_y_i,
    input  logic [9:0] ball_s_i,
    output logic       goal_p1_o,
    output logic       goal_p2_o
);

    localparam int unsigned CW = (GOAL_CONFIRM > 1) ? $clog2(GOAL_CONFIRM) : 1;
    localparam logic [CW-1:0] CONF_LAST   = CW'(GOAL_CONFIRM - 1);
    localparam logic [10:0]   LEFT_MOUTH  = 11'(GOAL_W);
    localparam logic [10:0]   RIGHT_MOUTH = 11'(SCREEN_W - GOAL_W);
    localparam logic [10:0]   CROSSBAR_Y  = 11'(FLOOR_Y - GOAL_H);

    logic [10:0]   ball_right;
    logic          q_left, q_right, award;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          side_q, side_d;

    assign ball_right = {1'b0, ball_x_i} + {1'b0, ball_s_i};
    assign q_left  = (ball_right <= LEFT_MOUTH) && ({1'b0, ball_y_i} >= CROSSBAR_Y);
    assign q_right = ({1'b0, ball_x_i} >= RIGHT_MOUTH) && ({1'b0, ball_y_i} >= CROSSBAR_Y);

    // side_q is 1 while the running streak belongs to the left goal.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        cnt_d  = '0;
        side_d = side_q;
        award  = 1'b0;
        if (enable_i && (q_left || q_right)) begin
            if ((cnt_q != '0) && (q_left != side_q)) begin
                cnt_d = '0;
            end else if (cnt_q == CONF_LAST) begin
                award = 1'b1;
            end else begin
                cnt_d  = cnt_q + CW'(1);
                side_d = q_left;
            end
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        // NOTE: state is updated with <= so every register samples pre-edge values.
        if (!Reset_n) begin
            cnt_q  <= '0;
            side_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            side_q <= side_d;
        end
    end

    assign goal_p1_o = award && q_right;
    assign goal_p2_o = award && q_left;

endmodule

// File: rtl/match_control.sv
// Per-frame match sequencer: kickoff, live play, goal celebration and game
// over, plus scores and the match clock. All outputs are registered.
module match_control
    import match_pkg::*;
#(
    parameter int unsigned GOAL_CONFIRM   = DEF_GOAL_CONFIRM,
    parameter int unsigned KICKOFF_FRAMES = DEF_KICKOFF_FRAMES,
    parameter int unsigned GOAL_FRAMES    = DEF_GOAL_FRAMES,
    parameter int unsigned FRAMES_PER_SEC = DEF_FRAMES_PER_SEC,
    parameter int unsigned MATCH_SECS     = DEF_MATCH_SECS,
    parameter int unsigned WIN_SCORE      = DEF_WIN_SCORE
) (
    input  logic           frame_clk,
    input  logic           Reset_n,
    match_control_if.slave bus
);

    localparam int unsigned FW = $clog2(FRAMES_PER_SEC);
    localparam logic [7:0]    KICK_LAST  = 8'(KICKOFF_FRAMES - 1);
    localparam logic [7:0]    GOAL_LAST  = 8'(GOAL_FRAMES - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
    localparam logic [6:0]    TIME_INIT  = 7'(MATCH_SECS);
    localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

    state_e        state_q, state_d;
    logic [7:0]    phase_q, phase_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [6:0]    time_q, time_d;
    logic [3:0]    score1_q, score1_d, score2_q, score2_d;
    logic          scorer_q, scorer_d;
    logic          start_prev_q;
    logic          ball_reset_q, ball_reset_d, frozen_q, frozen_d;
    logic          flash_q, flash_d, over_q, over_d;
    logic          clear_match, goal_p1, goal_p2;

    goal_detect #(.GOAL_CONFIRM(GOAL_CONFIRM)) u_goal_detect (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .enable_i  (state_q == ST_PLAY),
        .ball_x_i  (bus.BallX),
        .ball_y_i  (bus.BallY),
        .ball_s_i  (bus.BallS),
        .goal_p1_o (goal_p1),
        .goal_p2_o (goal_p2)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        frame_d     = frame_q;
        time_d      = time_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        scorer_d    = scorer_q;
        clear_match = 1'b0;

        unique case (state_q)
            ST_IDLE: if (bus.start) begin
                state_d     = ST_KICKOFF;
                clear_match = 1'b1;
            end
            ST_KICKOFF: if (phase_q == KICK_LAST) state_d = ST_PLAY;
                        else                      phase_d = phase_q + 8'd1;
            ST_PLAY: begin
                if (frame_q == FRAME_LAST) begin
                    frame_d = '0;
                    time_d  = time_q - 7'd1;
                    if (time_q == 7'd1) state_d = ST_OVER;
                end else begin
                    frame_d = frame_q + FW'(1);
                end
                // A goal on the expiry edge still counts; GOAL then exits to OVER.
                if (goal_p1) begin
                    score1_d = sat_inc(score1_q);
                    scorer_d = 1'b0;
                    state_d  = ST_GOAL;
                end else if (goal_p2) begin
                    score2_d = sat_inc(score2_q);
                    scorer_d = 1'b1;
                    state_d  = ST_GOAL;
                end
            end
            ST_GOAL: if (phase_q == GOAL_LAST) begin
                state_d = (score1_q >= WIN || score2_q >= WIN || time_q == '0) ? ST_OVER : ST_KICKOFF;
            end else begin
                phase_d = phase_q + 8'd1;
            end
            ST_OVER: if (bus.start && !start_prev_q) begin
                state_d     = ST_KICKOFF;
                clear_match = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear_match) begin
            score1_d = '0;
            score2_d = '0;
            frame_d  = '0;
            time_d   = TIME_INIT;
        end
        if (state_d != state_q) phase_d = '0;

        ball_reset_d = (state_d == ST_IDLE) || (state_d == ST_KICKOFF) || (state_d == ST_OVER);
        frozen_d     = (state_d != ST_PLAY);
        flash_d      = (state_d == ST_GOAL);
        over_d       = (state_d == ST_OVER);
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            frame_q      <= '0;
            time_q       <= TIME_INIT;
            score1_q     <= '0;
            score2_q     <= '0;
            scorer_q     <= 1'b0;
            start_prev_q <= 1'b0;
            ball_reset_q <= 1'b1;
            frozen_q     <= 1'b1;
            flash_q      <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            frame_q      <= frame_d;
            time_q       <= time_d;
            score1_q     <= score1_d;
            score2_q     <= score2_d;
            scorer_q     <= scorer_d;
            start_prev_q <= bus.start;
            ball_reset_q <= ball_reset_d;
            frozen_q     <= frozen_d;
            flash_q      <= flash_d;
            over_q       <= over_d;
        end
    end

    assign bus.state          = state_q;
    assign bus.ball_reset     = ball_reset_q;
    assign bus.players_frozen = frozen_q;
    assign bus.score1         = score1_q;
    assign bus.score2         = score2_q;
    assign bus.time_left      = time_q;
    assign bus.goal_flash     = flash_q;
    assign bus.scorer         = scorer_q;
    assign bus.game_over      = over_q;

endmodule

// File: tb/tb_match_control.sv
// Bench for match_control: directed vectors and sequences plus random play,
// every frame compared against a frame-level behavioural model.
module tb_match_control;
    import match_pkg::*;

    localparam int NX = 300, NY = 100, NS = 20;
    localparam logic [22:0] RESET_VEC = {3'd0, 1'b1, 1'b1, 4'd0, 4'd0, 7'd90, 1'b0, 1'b0, 1'b0};

    logic frame_clk = 1'b0;
    logic Reset_n;
    match_control_if bus();

    match_control dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    int checks = 0;
    int failures = 0;

    // Model: match clock is total live-play frames; time_left is derived by division.
    int m_state, m_phase, m_play, m_run, m_side, m_s1, m_s2;
    bit m_scorer, m_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_time();
        return int'(DEF_MATCH_SECS) - m_play / int'(DEF_FRAMES_PER_SEC);
    endfunction

    task automatic model_reset();
        m_state = 0; m_phase = 0; m_play = 0; m_run = 0; m_side = 0;
        m_s1 = 0; m_s2 = 0; m_scorer = 0; m_prev = 0;
    endtask

    task automatic model_step(input bit st, input int x, input int y, input int s);
        int q, nxt;
        bit clr;
        q = 0;
        clr = 0;
        if (y >= 250) begin
            if (x + s <= 80) q = 2;
            else if (x >= 560) q = 1;
        end
        nxt = m_state;
        case (m_state)
            0: if (st) begin nxt = 1; clr = 1; end
            1: begin m_phase++; if (m_phase == int'(DEF_KICKOFF_FRAMES)) nxt = 2; end
            2: begin
                m_play++;
                if (q != 0 && (m_run == 0 || q == m_side)) begin m_run++; m_side = q; end
                else m_run = 0;
                if (m_run == int'(DEF_GOAL_CONFIRM)) begin
                    if (q == 1) m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15;
                    else        m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15;
                    m_scorer = (q == 2);
                    nxt = 3;
                end else if (m_time() == 0) nxt = 4;
            end
            3: begin
                m_phase++;
                if (m_phase == int'(DEF_GOAL_FRAMES))
                    nxt = (m_s1 >= 5 || m_s2 >= 5 || m_time() == 0) ? 4 : 1;
            end
            default: if (st && !m_prev) begin nxt = 1; clr = 1; end
        endcase
        if (clr) begin m_s1 = 0; m_s2 = 0; m_play = 0; end
        if (nxt != m_state) m_phase = 0;
        if (nxt != 2) m_run = 0;
        m_state = nxt;
        m_prev = st;
    endtask

    function automatic logic [22:0] dut_vec();
        return {bus.state, bus.ball_reset, bus.players_frozen, bus.score1, bus.score2,
                bus.time_left, bus.goal_flash, bus.scorer, bus.game_over};
    endfunction

    function automatic logic [22:0] model_vec();
        return {3'(m_state), (m_state == 0 || m_state == 1 || m_state == 4), (m_state != 2),
                4'(m_s1), 4'(m_s2), 7'(m_time()), (m_state == 3), m_scorer, (m_state == 4)};
    endfunction

    task automatic tick(input bit st, input int x, input int y, input int s);
        bus.start = st;
        bus.BallX = 10'(x);
        bus.BallY = 10'(y);
        bus.BallS = 10'(s);
        @(posedge frame_clk);
        if (Reset_n) model_step(st, x, y, s);
        else         model_reset();
        #1;
        check("lockstep", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic run(input int n, input bit st, input int x, input int y, input int s);
        for (int i = 0; i < n; i++) tick(st, x, y, s);
    endtask

    task automatic enter_play();
        tick(1, NX, NY, NS);
        check("start_to_kickoff", 32'(bus.state), 32'd1);
        run(89, 0, NX, NY, NS);
        check("kickoff_hold", 32'(bus.state), 32'd1);
        tick(0, NX, NY, NS);
        check("kickoff_to_play", 32'(bus.state), 32'd2);
        check("play_ball_reset", 32'(bus.ball_reset), 32'd0);
        check("play_unfrozen", 32'(bus.players_frozen), 32'd0);
    endtask

    task automatic recover();
        run(119, 0, NX, NY, NS);
        check("goal_hold", 32'(bus.state), 32'd3);
        tick(0, NX, NY, NS);
        check("goal_to_kickoff", 32'(bus.state), 32'd1);
        run(89, 0, NX, NY, NS);
        tick(0, NX, NY, NS);
        check("rekick_to_play", 32'(bus.state), 32'd2);
    endtask

    task automatic async_reset();
        #2 Reset_n = 1'b0;
        #1 check("async_reset", 32'(dut_vec()), 32'(RESET_VEC));
        model_reset();
        @(posedge frame_clk);
        #1 check("reset_held", 32'(dut_vec()), 32'(RESET_VEC));
        Reset_n = 1'b1;
    endtask

    typedef struct {
        int x, y, s, frames, s1, s2, st, scorer;
    } vec_t;

    initial begin : main
        vec_t tbl[12];
        int   done, hold, cat, x, y, s;
        bit   st;

        tbl[0]  = '{570, 380, 20, 2,  1, 0, 3, 0};
        tbl[1]  = '{570, 380, 20, 1,  1, 0, 2, 0};
        tbl[2]  = '{300, 380, 20, 1,  1, 0, 2, 0};
        tbl[3]  = '{570, 380, 20, 1,  1, 0, 2, 0};
        tbl[4]  = '{300, 300, 20, 1,  1, 0, 2, 0};
        tbl[5]  = '{50,  380, 20, 2,  1, 1, 3, 1};
        tbl[6]  = '{570, 240, 20, 10, 1, 1, 2, 1};
        tbl[7]  = '{60,  380, 20, 2,  1, 2, 3, 1};
        tbl[8]  = '{61,  380, 20, 2,  1, 2, 2, 1};
        tbl[9]  = '{560, 250, 20, 2,  2, 2, 3, 0};
        tbl[10] = '{559, 300, 20, 2,  2, 2, 2, 0};
        tbl[11] = '{600, 249, 20, 2,  2, 2, 2, 0};

        bus.start = 1'b0;
        bus.BallX = 10'(NX);
        bus.BallY = 10'(NY);
        bus.BallS = 10'(NS);
        model_reset();
        Reset_n = 1'b1;
        #2 Reset_n = 1'b0;
        @(posedge frame_clk);
        @(posedge frame_clk);
        #1;
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_ball_reset", 32'(bus.ball_reset), 32'd1);
        check("rst_frozen", 32'(bus.players_frozen), 32'd1);
        check("rst_score1", 32'(bus.score1), 32'd0);
        check("rst_score2", 32'(bus.score2), 32'd0);
        check("rst_time_left", 32'(bus.time_left), 32'd90);
        check("rst_goal_flash", 32'(bus.goal_flash), 32'd0);
        check("rst_scorer", 32'(bus.scorer), 32'd0);
        check("rst_game_over", 32'(bus.game_over), 32'd0);
        Reset_n = 1'b1;

        enter_play();

        for (int i = 0; i < 12; i++) begin
            run(tbl[i].frames, 0, tbl[i].x, tbl[i].y, tbl[i].s);
            check($sformatf("vec%0d_state", i), 32'(bus.state), 32'(tbl[i].st));
            check($sformatf("vec%0d_score1", i), 32'(bus.score1), 32'(tbl[i].s1));
            check($sformatf("vec%0d_score2", i), 32'(bus.score2), 32'(tbl[i].s2));
            check($sformatf("vec%0d_scorer", i), 32'(bus.scorer), 32'(tbl[i].scorer));
            if (tbl[i].st == 3) recover();
        end

        done = 0;
        while (done < 3000) begin
            cat = $urandom_range(0, 3);
            s = $urandom_range(8, 24);
            case (cat)
                0: begin x = $urandom_range(0, 90 - s); y = $urandom_range(230, 400); end
                1: begin x = $urandom_range(550, 630);  y = $urandom_range(230, 400); end
                2: begin x = $urandom_range(100, 540);  y = $urandom_range(0, 400); end
                default: begin
                    x = $urandom_range(0, 1023); y = $urandom_range(0, 1023); s = $urandom_range(0, 1023);
                end
            endcase
            hold = $urandom_range(1, 3);
            for (int h = 0; h < hold; h++) begin
                st = ($urandom_range(0, 40) == 0);
                tick(st, x, y, s);
            end
            done += hold;
        end
        async_reset();

        enter_play();
        run(59, 0, NX, NY, NS);
        check("time_before_wrap", 32'(bus.time_left), 32'd90);
        tick(0, NX, NY, NS);
        check("time_after_wrap", 32'(bus.time_left), 32'd89);
        run(5339, 0, NX, NY, NS);
        check("time_last_sec", 32'(bus.time_left), 32'd1);
        check("still_play", 32'(bus.state), 32'd2);
        tick(1, NX, NY, NS);
        check("expiry_state", 32'(bus.state), 32'd4);
        check("expiry_time", 32'(bus.time_left), 32'd0);
        check("expiry_game_over", 32'(bus.game_over), 32'd1);
        run(5, 1, NX, NY, NS);
        check("held_start_no_restart", 32'(bus.state), 32'd4);
        tick(0, NX, NY, NS);
        check("released_start", 32'(bus.state), 32'd4);
        tick(1, NX, NY, NS);
        check("restart_state", 32'(bus.state), 32'd1);
        check("restart_time", 32'(bus.time_left), 32'd90);
        check("restart_scores", 32'({bus.score1, bus.score2}), 32'd0);

        run(89, 0, NX, NY, NS);
        tick(0, NX, NY, NS);
        check("sim_play", 32'(bus.state), 32'd2);
        run(5398, 0, NX, NY, NS);
        run(2, 0, 570, 380, 20);
        check("sim_goal_state", 32'(bus.state), 32'd3);
        check("sim_goal_score1", 32'(bus.score1), 32'd1);
        check("sim_goal_time", 32'(bus.time_left), 32'd0);
        run(119, 0, NX, NY, NS);
        check("sim_goal_hold", 32'(bus.state), 32'd3);
        tick(0, NX, NY, NS);
        check("sim_goal_to_over", 32'(bus.state), 32'd4);

        enter_play();
        for (int g = 1; g <= 5; g++) begin
            run(2, 0, 570, 380, 20);
            check($sformatf("win_goal%0d_score1", g), 32'(bus.score1), 32'(g));
            check($sformatf("win_goal%0d_state", g), 32'(bus.state), 32'd3);
            if (g < 5) recover();
        end
        run(119, 0, NX, NY, NS);
        check("win_celebration", 32'(bus.state), 32'd3);
        tick(0, NX, NY, NS);
        check("win_over_state", 32'(bus.state), 32'd4);
        check("win_game_over", 32'(bus.game_over), 32'd1);

        enter_play();
        run(2, 0, 50, 380, 20);
        check("midgoal_state", 32'(bus.state), 32'd3);
        check("midgoal_score2", 32'(bus.score2), 32'd1);
        run(50, 0, NX, NY, NS);
        async_reset();
        run(3, 0, NX, NY, NS);
        check("post_reset_idle", 32'(bus.state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
